// File: rtl/feather_pkg.sv
// Shared types for the feather fetch path: instruction word and FIFO entry payload.
package feather_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    instr_t            instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries; flush wins over push and pop.
module fetch_fifo
  import feather_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  fetch_entry_t  mem [DEPTH];

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // The issue rule reserves a slot for every granted request.
  push_into_full: assert property (@(posedge clk) disable iff (!reset_ni)
    !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues word reads, buffers responses and
// presents them to the core with their PC and the PC+8 value for r15 reads.
module instruction_fetch
  import feather_pkg::*;
#(
  parameter int unsigned       ADDR_W   = feather_pkg::ADDR_W,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_ni,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic [ADDR_W-1:0] instr_pc8_o,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              pop;
  logic              push;
  logic              grant;
  fetch_entry_t      wentry;
  fetch_entry_t      head;
  logic              unused_target_lsb;

  assign unused_target_lsb = ^branch_target_i[1:0];

  assign pop = instr_valid_o & instr_ready_i;

  // Slots committed after this cycle; never negative since pop implies count >= 1.
  assign occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

  assign mem_req_o  = reset_ni & ~branch_i & (occupancy < (CW+1)'(DEPTH));
  assign mem_addr_o = fetch_pc;
  assign grant      = mem_req_o & mem_gnt_i;
  assign push       = inflight & ~branch_i;

  assign wentry.instr = mem_rdata_i;
  assign wentry.pc    = inflight_pc;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (branch_i) begin
      fetch_pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= grant;
      if (grant) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_ni (reset_ni),
    .push     (push),
    .pop      (pop),
    .flush    (branch_i),
    .wdata    (wentry),
    .head     (head),
    .count    (count)
  );

  // Head is masked to zero when empty so stale flushed data never shows.
  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc : '0;
  assign instr_pc8_o   = instr_pc_o + ADDR_W'(8);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the single-issue core: owns the fetch PC, issues word reads to the synchronous program memory, buffers returned words with their addresses in a small prefetch FIFO, and hands them to the core over a valid/ready handshake. Redirects on taken branches by flushing buffered and in-flight words. Supplies the ARM-style PC+8 value that the core feeds to the register file's r15 read port.

## Interface
- ADDR_W, 8, byte-address width of program memory and all PC values
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 0, first fetch address after reset (word aligned)

- clk  in  1  clock, all state updates on rising edge
- reset_ni  in  1  synchronous, active-low reset
- mem_req_o  out  1  read request this cycle
- mem_addr_o  out  ADDR_W  byte address of request, bits [1:0] always 0
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rdata_i  in  32  read data, valid exactly one cycle after a granted request
- instr_valid_o  out  1  instr_o/pc outputs hold a valid entry
- instr_ready_i  in  1  core consumes entry this cycle
- instr_o  out  32  instruction word at FIFO head
- instr_pc_o  out  ADDR_W  address of instr_o
- instr_pc8_o  out  ADDR_W  instr_pc_o + 8, modulo 2^ADDR_W
- branch_i  in  1  redirect fetch this cycle
- branch_target_i  in  ADDR_W  redirect address; bits [1:0] ignored (treated as 0)

## Operation
- State: fetch_pc, inflight flag (granted request whose data arrives next cycle), inflight_pc, FIFO of {instr, pc}, count.
- Reset (reset_ni low at edge): fetch_pc ← RESET_PC, inflight ← 0, count ← 0. During and after reset until first push: mem_req_o 0 while reset asserted, instr_valid_o 0, instr_o 0, instr_pc_o 0, instr_pc8_o 8.
- pop = instr_valid_o & instr_ready_i.
- Issue rule: mem_req_o = ~branch_i & (count + inflight − pop < DEPTH); mem_addr_o = fetch_pc.
- On mem_req_o & mem_gnt_i: inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (wraps 0xFC → 0x00 at ADDR_W=8). Otherwise inflight ← 0 and fetch_pc holds.
- Response: if inflight was 1 the previous cycle, push {mem_rdata_i, inflight_pc} this cycle. Issue rule guarantees space; push into a full FIFO is an assertion failure.
- Simultaneous push and pop: both occur, count unchanged.
- Branch (branch_i high): FIFO cleared (count ← 0), any response arriving this cycle dropped, inflight ← 0 (response arriving next cycle belongs to no request issued this cycle and is ignored), fetch_pc ← {branch_target_i[ADDR_W-1:2], 2'b00}, no request this cycle. A pop in the same cycle completes the core's handshake; the entry is discarded with the flush.
- mem_gnt_i low: request held at same address, retried every cycle, no data expected.
- Reset mid-operation overrides branch, push and pop; all state returns to reset values.

## Timing
- Request cycle N (granted) → data pushed end of N+1 → instr_valid_o visible N+2. No bypass from mem_rdata_i to instr_o.
- First instruction after reset release (cycle 0 = first cycle reset_ni high): request addr RESET_PC at cycle 0, instr_valid_o at cycle 2.
- Branch in cycle B: request target at B+1, target instruction valid at B+3 (2 dead cycles).
- Steady state with instr_ready_i high and mem_gnt_i high: one instruction per cycle, consecutive PCs.
- instr_valid_o, instr_o, instr_pc_o, instr_pc8_o are registered (FIFO head), stable while instr_valid_o & ~instr_ready_i and no branch.

## Structure
- feather_pkg: ADDR_W default, instr_t (32-bit), fetch_entry_t struct {instr_t instr; logic [ADDR_W-1:0] pc}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, head output; flush priority over push/pop.
- instruction_fetch holds PC, inflight tracking, issue rule and pc8 adder.

## Test plan
- Reset: hold reset_ni low 3 cycles mid-stream → all outputs at reset values; after release mem_addr_o 0x00 at cycle 0, instr_valid_o with instr_pc_o 0x00, instr_pc8_o 0x08 at cycle 2.
- Streaming: memory returns word = address, ready high → instr_pc_o 0x00,0x04,0x08,… one per cycle, instr_o matching.
- Backpressure: ready low for 5 cycles after first valid → at most DEPTH entries buffered, mem_req_o drops, outputs stable; on release no entry lost or duplicated.
- Grant stalls: mem_gnt_i low on alternate cycles → mem_addr_o repeats until granted, in-order delivery, no gaps in PC sequence.
- Branch with FIFO full and request in flight: branch_i at 0x10, target 0x43 → flushed entries never appear, next valid instr_pc_o 0x40 exactly 3 cycles later.
- Wrap: branch to 0xF8 → instr_pc_o 0xF8, 0xFC, 0x00; instr_pc8_o 0x00, 0x04, 0x08.
